char_glyph_fetch: RTL

//   Glyph fetch stage sitting directly upstream of the character pixel handler.
//   On each readEn request it fetches one 8-pixel glyph row from an external synchronous font ROM.
//   The address is formed from the current character code and the row index.
//   It holds that row in a register and presents the pixel addressed by colCnt as bitDisp.
//   It sits between the font ROM and the handler; the handler's vgaRGB gating consumes bitDisp.

---
 rtl/char_glyph_fetch.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/char_glyph_fetch.sv
// -----------------------------------------------------------------------------
// char_glyph_fetch
//
// Purpose:
//   Glyph fetch stage in front of the character pixel handler. A one-cycle
//   readEn request latches {charCode,rowCnt} as the font ROM address, issues a
//   single ROM read strobe, waits out the ROM latency and captures the returned
//   8-pixel row. The held row is indexed by colCnt to produce bitDisp.
//
// Ports:
//   clock      in   system clock, all state on posedge
//   reset      in   synchronous, active-high
//   frameStart in   one-cycle pulse, blanks the held row (a LOAD in the same
//                   cycle takes priority)
//   readEn     in   one-cycle fetch request; ignored (and flagged) while busy
//   charCode   in   character code, sampled with readEn
//   rowCnt     in   glyph row index, sampled with readEn
//   colCnt     in   pixel column within the glyph (0..7)
//   romAddr    out  font ROM address {charCode,rowCnt}, held until next accept
//   romRdEn    out  font ROM read strobe, high for the single ISSUE cycle
//   romData    in   font ROM data, valid ROM_LAT clocks after romRdEn
//   bitDisp    out  selected glyph pixel, combinational from the held row
//   busy       out  high in ISSUE, WAIT and LOAD
//   overrun    out  sticky flag: readEn seen while busy; cleared by reset only
// -----------------------------------------------------------------------------
module char_glyph_fetch #(
    parameter int CODE_W    = 7,
    parameter int ROW_W     = 4,
    parameter int ROM_LAT   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      frameStart,
    input  logic                      readEn,
    input  logic [CODE_W-1:0]         charCode,
    input  logic [ROW_W-1:0]          rowCnt,
    input  logic [2:0]                colCnt,
    output logic [CODE_W+ROW_W-1:0]   romAddr,
    output logic                      romRdEn,
    input  logic [7:0]                romData,
    output logic                      bitDisp,
    output logic                      busy,
    output logic                      overrun
);

    localparam int ADDR_W = CODE_W + ROW_W;

    // Counter preload for the WAIT state: ISSUE and LOAD already account for
    // two of the ROM_LAT+1 busy cycles, so WAIT runs ROM_LAT-1 cycles,
    // counting ROM_LAT-2 down to 0. Unused when ROM_LAT==1.
    localparam logic [1:0] LAT_INIT = (ROM_LAT >= 2) ? 2'(ROM_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [1:0]         cnt_q,   cnt_d;
    logic [7:0]         row_q,   row_d;
    logic               ovr_q,   ovr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= 2'd0;
            row_q   <= 8'h00;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        ovr_d   = ovr_q;

        // Blanking comes first so that a LOAD in the same cycle overrides it.
        if (frameStart) begin
            row_d = 8'h00;
        end

        case (state_q)
            ST_IDLE: begin
                if (readEn) begin
                    state_d = ST_ISSUE;
                    addr_d  = {charCode, rowCnt};
                end
            end
            ST_ISSUE: begin
                cnt_d   = LAT_INIT;
                state_d = (ROM_LAT == 1) ? ST_LOAD : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_LOAD: begin
                row_d   = romData;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A request that lands while a fetch is in flight is dropped.
        if (readEn && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    // Strobe decoded straight from state so it drops on the same edge as reset.
    assign romRdEn = (state_q == ST_ISSUE);
    assign busy    = (state_q != ST_IDLE);
    assign romAddr = addr_q;
    assign overrun = ovr_q;

    // The downstream handler registers bitDisp, so no output flop here.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign bitDisp = row_q[3'd7 - colCnt];
        end else begin : g_lsb_first
            assign bitDisp = row_q[colCnt];
        end
    endgenerate

endmodule
